// File: rtl/vc_output_scheduler_if.sv
// Two-VC output scheduler handshake bundle.
// master = scheduler side, slave = requesters plus downstream.
interface vc_output_scheduler_if #(
  parameter int DATA_W = 64
);
  logic [1:0]        req;
  logic [DATA_W-1:0] d0;
  logic [DATA_W-1:0] d1;
  logic [1:0]        gnt;
  logic              polarity;
  logic              so;
  logic              ro;
  logic [DATA_W-1:0] dout;

  modport master (
    input  req, d0, d1, ro,
    output gnt, polarity, so, dout
  );

  modport slave (
    output req, d0, d1, ro,
    input  gnt, polarity, so, dout
  );
endinterface

// File: rtl/vc_output_scheduler.sv
// Two-VC output scheduler: alternating phases, one buffer per VC,
// LRU arbitration per VC. Optional counters: SCHED_STATS_EN.
module vc_output_scheduler #(
  parameter int DATA_W  = 64,
  parameter int HOP_LSB = 48,
  parameter int HOP_DEC = 1
) (
  input  logic clk,
  input  logic reset,
`ifdef SCHED_STATS_EN
  input  logic        stats_clr,
  output logic [15:0] cnt0,
  output logic [15:0] cnt1,
`endif
  vc_output_scheduler_if.master bus
);

  typedef enum logic {
    PH_ODD  = 1'b0,
    PH_EVEN = 1'b1
  } phase_t;

  phase_t phase_q, phase_d;

  logic [1:0]             full_q, full_d;
  logic [1:0]             lru_q, lru_d;
  logic [1:0][DATA_W-1:0] obuf_q, obuf_d;

  logic              p;
  logic [1:0]        gnt;
  logic              xfer;
  logic              win;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] cap;

  assign p = (phase_q == PH_EVEN);

  // Grant: blocked by a full buffer or reset, LRU breaks ties.
  always_comb begin
    gnt = 2'b00;
    if (!reset && !full_q[p]) begin
      case (bus.req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = lru_q[p] ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign xfer  = |(bus.req & gnt);
  assign win   = gnt[1];
  assign wdata = win ? bus.d1 : bus.d0;

  generate
    if (HOP_DEC != 0) begin : g_hop_dec
      // Hop field decrements on capture, wrapping 00 to FF.
      always_comb begin
        cap = wdata;
        cap[HOP_LSB +: 8] = wdata[HOP_LSB +: 8] - 8'd1;
      end
    end else begin : g_hop_pass
      assign cap = wdata;
    end
  endgenerate

  // Next state: phase toggle, load on transfer, else drain.
  always_comb begin
    phase_d = (phase_q == PH_ODD) ? PH_EVEN : PH_ODD;
    full_d  = full_q;
    lru_d   = lru_q;
    obuf_d  = obuf_q;
    if (xfer) begin
      obuf_d[p] = cap;
      full_d[p] = 1'b1;
      lru_d[p]  = ~win;
    end else if (full_q[p] && bus.ro) begin
      full_d[p] = 1'b0;
    end
  end

  // State registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= PH_ODD;
      full_q  <= '0;
      lru_q   <= '0;
      obuf_q  <= '0;
    end else begin
      phase_q <= phase_d;
      full_q  <= full_d;
      lru_q   <= lru_d;
      obuf_q  <= obuf_d;
    end
  end

  assign bus.gnt      = gnt;
  assign bus.polarity = p;
  assign bus.so       = full_q[p];
  assign bus.dout     = obuf_q[p];

`ifdef SCHED_STATS_EN
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;

  // Saturating per-requester transfer counters; clear wins.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (stats_clr) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else if (xfer) begin
      if (!win && cnt0_q != 16'hFFFF) cnt0_d = cnt0_q + 16'd1;
      if (win && cnt1_q != 16'hFFFF)  cnt1_d = cnt1_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: doc/vc_output_scheduler.md
VC_OUTPUT_SCHEDULER -- requirements
Module: vc_output_scheduler

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, packet width in bits.
REQ-002 The block SHALL have parameter HOP_LSB, default 48, LSB of the 8-bit hop field, which occupies [HOP_LSB+7:HOP_LSB].
REQ-003 The block SHALL have parameter HOP_DEC, default 1: 1 = decrement the hop field on capture, 0 = pass packets through unmodified.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port req, input, 2 bits: per-requester request for the VC selected by the current polarity.
REQ-007 The block SHALL have ports d0 and d1, input, DATA_W bits each: packets from requesters 0 and 1.
REQ-008 The block SHALL have port gnt, output, 2 bits: one-hot grant, combinational; a transfer occurs on the rising edge where req[i] and gnt[i] are both 1.
REQ-009 The block SHALL have port polarity, output, 1 bit: current phase, 0 = odd VC, 1 = even VC.
REQ-010 The block SHALL have port so, output, 1 bit: output-buffer valid for the current VC.
REQ-011 The block SHALL have port ro, input, 1 bit: downstream ready for the current VC.
REQ-012 The block SHALL have port dout, output, DATA_W bits: output-buffer content for the current VC.

Function
REQ-013 Polarity SHALL toggle every cycle when not in reset.
REQ-014 The block SHALL hold one output buffer per VC, buf[p] with flag full[p], where p = polarity.
REQ-015 gnt SHALL be 00 when full[p]=1, when req=00, or during reset.
REQ-016 With exactly one req bit set and full[p]=0, gnt SHALL equal req.
REQ-017 With req=11 and full[p]=0, gnt SHALL select the requester indicated by lru[p]; there SHALL be one lru bit per VC.
REQ-018 On a transfer from requester i, the block SHALL set buf[p] to the winner's data, set full[p] to 1, and set lru[p] to 1-i; lru[1-p] SHALL be unchanged.
REQ-019 With HOP_DEC=1, the captured hop field SHALL be the input hop field minus 1 modulo 256 (00 becomes FF); all other bits SHALL be copied unchanged.
REQ-020 so SHALL equal full[p], and dout SHALL equal buf[p] in the same cycle.
REQ-021 On a rising edge with full[p]=1 and ro=1, full[p] SHALL clear; buf[p] SHALL retain its value.
REQ-022 Drain and load of the same VC SHALL NOT occur in one cycle; after a drain, the earliest reload of that VC SHALL be 2 cycles later.
REQ-023 The two VCs SHALL be fully independent: a full odd buffer SHALL never block even grants.
REQ-024 Requesters may hold req across phases; a request SHALL only be considered in the phase of the current polarity.

Reset
REQ-025 Asserting reset SHALL immediately set polarity=0, full=00, lru=00 (requester 0 preferred) and buf=0.
REQ-026 During reset, outputs SHALL be so=0, gnt=00, dout=0.
REQ-027 A reset asserted mid-operation SHALL discard buffered packets and perform no drain handshake.
REQ-028 The first cycle after reset deassertion SHALL be odd phase (polarity=0).

Configuration
REQ-029 With macro SCHED_STATS_EN defined, the block SHALL add input stats_clr (1 bit) and outputs cnt0 and cnt1 (16 bits each), counting transfers per requester across both VCs.
REQ-030 When SCHED_STATS_EN is defined, the counters SHALL saturate at FFFF and reset to 0.
REQ-031 When SCHED_STATS_EN is defined, stats_clr SHALL zero both counters on the next edge and take priority over a simultaneous transfer.
REQ-032 Without SCHED_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 Scenario: reset, then req=01 in phase 0 with d0 hop=05 -> gnt=01; next cycle so=0 (phase 1); following cycle so=1 with dout hop=04.
REQ-034 Scenario: req=11 in phase 0 repeatedly with ro=1 -> odd grants alternate 0,1,0,1; even-VC lru is unaffected.
REQ-035 Scenario: odd buffer full with ro=0 and req=01 held -> gnt=00 in every odd phase while even grants continue; ro=1 drains, and the odd grant reappears 2 cycles later.
REQ-036 Scenario: hop=00 with HOP_DEC=1 -> dout hop=FF; with HOP_DEC=0 -> dout equals the input bit for bit.
REQ-037 Scenario: reset asserted while both buffers are full -> so=0 and gnt=00 immediately, and polarity=0.
REQ-038 Scenario: with SCHED_STATS_EN, cnt0 preloaded to FFFF plus a grant -> cnt0 stays FFFF; stats_clr together with a grant -> cnt0=0.
